// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC decimation controller.
package cic_pkg;

  typedef enum logic {
    CIC_CLEAR = 1'b0,
    CIC_RUN   = 1'b1
  } cic_state_e;

  localparam int CIC_DEFAULT_RATIO = 8;
  localparam int CIC_MIN_RATIO     = 2;

  // Bit growth of an N-stage CIC is N*ceil(log2(R)); fixed bounds keep the loop synthesizable.
  function automatic int cic_gain_shift(input int stages, input int ratio);
    int lg;
    lg = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < ratio) lg = i + 1;
    end
    return stages * lg;
  endfunction

endpackage

// File: rtl/cic_rate_counter.sv
// Modulo-R sample counter; wrap marks acceptance of the R-th sample of a frame.
module cic_rate_counter #(
  parameter int RATIO_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clr,
  input  logic [RATIO_W-1:0] ratio,
  output logic               last,
  output logic               wrap
);

  logic [RATIO_W-1:0] r_count;

  assign last = (r_count == ratio - RATIO_W'(1));
  assign wrap = inc && last;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= wrap ? '0 : r_count + RATIO_W'(1);
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimation sequencer: clear/run FSM, input/cfg/output handshakes and comb timing.
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int STAGES        = 3,
  parameter int RATIO_W       = 8,
  parameter int DEFAULT_RATIO = CIC_DEFAULT_RATIO,
  parameter int MIN_RATIO     = CIC_MIN_RATIO,
  parameter int SHIFT_W       = $clog2(STAGES * RATIO_W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               cfg_valid,
  input  logic [RATIO_W-1:0] cfg_ratio,
  output logic               cfg_ready,
  output logic               integ_en,
  output logic               integ_clr,
  output logic               comb_en,
  output logic               comb_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SHIFT_W-1:0] gain_shift,
  output logic               busy
);

  localparam int CLR_W = $clog2(STAGES + 1);

  cic_state_e         r_state;
  logic [CLR_W-1:0]   r_clr_cnt;
  logic [RATIO_W-1:0] r_ratio;
  logic [SHIFT_W-1:0] r_gain_shift;
  logic               r_comb_en;
  logic               r_out_valid;

  logic               w_run;
  logic               w_cfg_hs;
  logic               w_stall;
  logic               w_last;
  logic               w_wrap;
  logic               w_cnt_clr;
  logic [RATIO_W-1:0] w_new_ratio;

  assign w_run       = (r_state == CIC_RUN);
  assign cfg_ready   = w_run && !r_out_valid && !r_comb_en;
  assign w_cfg_hs    = cfg_valid && cfg_ready;
  // Only the frame-closing sample waits on the consumer; earlier samples keep flowing.
  assign w_stall     = w_last && r_out_valid && !out_ready;
  assign in_ready    = w_run && !w_cfg_hs && !w_stall;
  assign integ_en    = in_valid && in_ready;
  assign integ_clr   = !w_run;
  assign comb_clr    = !w_run;
  assign busy        = !w_run;
  assign comb_en     = r_comb_en;
  assign out_valid   = r_out_valid;
  assign gain_shift  = r_gain_shift;
  assign w_cnt_clr   = !w_run || w_cfg_hs;
  assign w_new_ratio = (cfg_ratio < RATIO_W'(MIN_RATIO)) ? RATIO_W'(MIN_RATIO) : cfg_ratio;

  cic_rate_counter #(
    .RATIO_W (RATIO_W)
  ) u_rate_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (integ_en),
    .clr   (w_cnt_clr),
    .ratio (r_ratio),
    .last  (w_last),
    .wrap  (w_wrap)
  );

  // NOTE: every control register is async-reset so outputs fall to safe values without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= CIC_CLEAR;
      r_clr_cnt    <= '0;
      r_ratio      <= RATIO_W'(DEFAULT_RATIO);
      r_gain_shift <= SHIFT_W'(cic_gain_shift(STAGES, DEFAULT_RATIO));
      r_comb_en    <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_comb_en <= w_wrap;

      // A new result outranks consumption of the previous one.
      if (r_comb_en) begin
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        CIC_CLEAR: begin
          if (r_clr_cnt == CLR_W'(STAGES)) begin
            r_state   <= CIC_RUN;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + CLR_W'(1);
          end
        end
        CIC_RUN: begin
          if (w_cfg_hs) begin
            r_state      <= CIC_CLEAR;
            r_clr_cnt    <= '0;
            r_ratio      <= w_new_ratio;
            r_gain_shift <= SHIFT_W'(cic_gain_shift(STAGES, int'(w_new_ratio)));
          end
        end
        default: r_state <= CIC_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed self-checking bench for cic_decim_ctrl with hand-derived expectations.
module tb_cic_decim_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       cfg_valid;
  logic [7:0] cfg_ratio;
  logic       cfg_ready;
  logic       integ_en;
  logic       integ_clr;
  logic       comb_en;
  logic       comb_clr;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] gain_shift;
  logic       busy;

  int total = 0;
  int bad   = 0;

  cic_decim_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cfg_valid  (cfg_valid),
    .cfg_ratio  (cfg_ratio),
    .cfg_ready  (cfg_ready),
    .integ_en   (integ_en),
    .integ_clr  (integ_clr),
    .comb_en    (comb_en),
    .comb_clr   (comb_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .gain_shift (gain_shift),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four CLEAR cycles starting in the current cycle, then RUN with in_ready high.
  task automatic wait_clear(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (busy !== 1'b1 || integ_clr !== 1'b1 || comb_clr !== 1'b1 ||
          in_ready !== 1'b0 || cfg_ready !== 1'b0 || out_valid !== 1'b0) errs++;
      tick();
    end
    #1;
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL %s_clear_cycles: bad cycles=%0d expected 0", tag, errs);
    end
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_run_entry: busy=%b in_ready=%b expected busy=0 in_ready=1", tag, busy, in_ready);
    end
  endtask

  // Idle cfg handshake followed by the clear sequence and the new gain shift.
  task automatic do_cfg(input int ratio, input int exp_shift, input string tag);
    in_valid  = 1'b0;
    cfg_valid = 1'b1;
    cfg_ratio = 8'(ratio);
    #1;
    total++;
    if (cfg_ready !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_handshake: cfg_ready=%b in_ready=%b expected 1/0", tag, cfg_ready, in_ready);
    end
    tick();
    cfg_valid = 1'b0;
    wait_clear(tag);
    total++;
    if (gain_shift !== 5'(exp_shift)) begin
      bad++;
      $display("FAIL %s_gain_shift: got %0d expected %0d", tag, gain_shift, exp_shift);
    end
  endtask

  // Continuous stream of n samples at ratio r with out_ready held high, plus two drain cycles.
  task automatic run_stream(input int r, input int n, input string tag);
    int   cnt_m, pulses, errs;
    logic exp_comb, exp_ov;
    cnt_m = 0; pulses = 0; errs = 0;
    exp_comb = 1'b0; exp_ov = 1'b0;
    out_ready = 1'b1;
    cfg_valid = 1'b0;
    for (int i = 0; i < n + 2; i++) begin
      in_valid = (i < n);
      #1;
      if (in_ready !== 1'b1 || integ_en !== 1'(i < n) ||
          comb_en !== exp_comb || out_valid !== exp_ov) errs++;
      if (comb_en === 1'b1) pulses++;
      exp_ov   = exp_comb;
      exp_comb = (i < n) && (cnt_m == r - 1);
      if (i < n) cnt_m = (cnt_m + 1) % r;
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL %s_timing: mismatching cycles=%0d expected 0", tag, errs);
    end
    total++;
    if (pulses !== n / r) begin
      bad++;
      $display("FAIL %s_comb_pulses: got %0d expected %0d", tag, pulses, n / r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; cfg_valid = 1'b0; cfg_ratio = 8'd0; out_ready = 1'b0;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b0 || cfg_ready !== 1'b0 || integ_en !== 1'b0 || comb_en !== 1'b0 ||
        out_valid !== 1'b0 || integ_clr !== 1'b1 || comb_clr !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_values: in_ready=%b cfg_ready=%b integ_en=%b comb_en=%b out_valid=%b integ_clr=%b comb_clr=%b busy=%b expected 0 0 0 0 0 1 1 1",
               in_ready, cfg_ready, integ_en, comb_en, out_valid, integ_clr, comb_clr, busy);
    end
    reset = 1'b1;
    wait_clear("reset");
    total++;
    if (gain_shift !== 5'd9 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_defaults: gain_shift=%0d cfg_ready=%b expected 9/1", gain_shift, cfg_ready);
    end
  endtask

  task automatic test_continuous();
    run_stream(8, 800, "cont_r8");
  endtask

  task automatic test_stall();
    int acc;
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      out_ready = (i < 8);
      #1;
      if (integ_en === 1'b1) acc++;
      if (i == 8) begin
        total++;
        if (comb_en !== 1'b1) begin
          bad++;
          $display("FAIL stall_first_comb: comb_en=%b expected 1", comb_en);
        end
      end
      if (i == 15 || i == 16) begin
        total++;
        if (in_ready !== 1'b0 || integ_en !== 1'b0 || out_valid !== 1'b1 || cfg_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold_%0d: in_ready=%b integ_en=%b out_valid=%b cfg_ready=%b expected 0 0 1 0",
                   i, in_ready, integ_en, out_valid, cfg_ready);
        end
      end
      tick();
    end
    total++;
    if (acc !== 15) begin
      bad++;
      $display("FAIL stall_accepted: got %0d expected 15", acc);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || integ_en !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: in_ready=%b integ_en=%b expected 1/1", in_ready, integ_en);
    end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (comb_en !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_second_comb: comb_en=%b out_valid=%b expected 1/0", comb_en, out_valid);
    end
    tick();
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_second_out: out_valid=%b expected 1", out_valid);
    end
    tick();
  endtask

  task automatic test_cfg_pending();
    int errs;
    errs = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      tick();
    end
    in_valid  = 1'b0;
    cfg_valid = 1'b1;
    cfg_ratio = 8'd4;
    for (int i = 8; i < 11; i++) begin
      #1;
      if (cfg_ready !== 1'b0 || busy !== 1'b0) errs++;
      tick();
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL cfg_blocked: cycles with cfg_ready/busy set=%0d expected 0", errs);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (cfg_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL cfg_consume_cycle: cfg_ready=%b out_valid=%b expected 0/1", cfg_ready, out_valid);
    end
    tick();
    in_valid = 1'b1;
    #1;
    total++;
    if (cfg_ready !== 1'b1 || in_ready !== 1'b0 || integ_en !== 1'b0) begin
      bad++;
      $display("FAIL cfg_accept: cfg_ready=%b in_ready=%b integ_en=%b expected 1 0 0", cfg_ready, in_ready, integ_en);
    end
    tick();
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    wait_clear("cfg_r4");
    total++;
    if (gain_shift !== 5'd6) begin
      bad++;
      $display("FAIL cfg_r4_gain_shift: got %0d expected 6", gain_shift);
    end
    run_stream(4, 16, "stream_r4");
  endtask

  task automatic test_clamp();
    do_cfg(1, 3, "clamp_r1");
    run_stream(2, 10, "stream_r2");
    do_cfg(5, 9, "cfg_r5");
    run_stream(5, 10, "stream_r5");
  endtask

  task automatic test_async_reset();
    do_cfg(16, 12, "cfg_r16");
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tick();
    end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || cfg_ready !== 1'b0 || integ_en !== 1'b0 || comb_en !== 1'b0 ||
        out_valid !== 1'b0 || integ_clr !== 1'b1 || comb_clr !== 1'b1 || busy !== 1'b1 ||
        gain_shift !== 5'd9) begin
      bad++;
      $display("FAIL async_reset_values: in_ready=%b cfg_ready=%b integ_en=%b comb_en=%b out_valid=%b integ_clr=%b comb_clr=%b busy=%b gain_shift=%0d expected 0 0 0 0 0 1 1 1 9",
               in_ready, cfg_ready, integ_en, comb_en, out_valid, integ_clr, comb_clr, busy, gain_shift);
    end
    tick();
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    wait_clear("post_reset");
    run_stream(8, 8, "post_reset_r8");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_continuous();
    test_stall();
    test_cfg_pending();
    test_clamp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
